// File: rtl/param_seq_detector.sv
// Mealy serial pattern detector with a runtime-loadable pattern, overlap/non-overlap modes and
// a saturating match counter. Define SEQ_DET_MASK_EN to add a live don't-care mask (pat_mask).
module param_seq_detector #(
    parameter int              PAT_W       = 5,
    parameter int              CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(5'b10110)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_en,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] pat_mask,
`endif
    input  logic             cnt_clr,
    output logic             pattern_dect,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int               FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] match_count_q, match_count_d;
    logic             count_sat_q, count_sat_d;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask_eff;
    logic             match;

`ifdef SEQ_DET_MASK_EN
    assign mask_eff = pat_mask;
`else
    assign mask_eff = {PAT_W{1'b1}};
`endif

    // The newest bit joins the history as the LSB, so the first-received bit lines up with pat MSB.
    assign window = {hist_q, data_in};
    assign match  = valid && !pat_load && !rst && (fill_q == FILL_MAX)
                    && (((window ^ pat_q) & mask_eff) == '0);

    always_comb begin
        hist_d        = hist_q;
        fill_d        = fill_q;
        pat_d         = pat_q;
        match_count_d = match_count_q;
        count_sat_d   = count_sat_q;

        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (valid) begin
            hist_d = window[PAT_W-2:0];
            if (match && !overlap_en) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end

        // Clear wins over a coincident increment.
        if (cnt_clr) begin
            match_count_d = '0;
        end else if (match && (match_count_q != CNT_MAX)) begin
            match_count_d = match_count_q + 1'b1;
        end
        count_sat_d = (match_count_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q        <= '0;
            fill_q        <= '0;
            pat_q         <= DEFAULT_PAT;
            match_count_q <= '0;
            count_sat_q   <= 1'b0;
        end else begin
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            pat_q         <= pat_d;
            match_count_q <= match_count_d;
            count_sat_q   <= count_sat_d;
        end
    end

    assign pattern_dect = match;
    assign match_count  = match_count_q;
    assign count_sat    = count_sat_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector built with a 2-bit counter so saturation is reachable.
module tb_param_seq_detector;

    localparam int PAT_W = 5;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             data_in = 1'b0;
    logic             valid = 1'b0;
    logic             pat_load = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic             overlap_en = 1'b1;
    logic             cnt_clr = 1'b0;
    logic             pattern_dect;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] pat_mask = '1;
`endif

    int total = 0;
    int bad   = 0;

    param_seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .valid        (valid),
        .pat_load     (pat_load),
        .pat_in       (pat_in),
        .overlap_en   (overlap_en),
`ifdef SEQ_DET_MASK_EN
        .pat_mask     (pat_mask),
`endif
        .cnt_clr      (cnt_clr),
        .pattern_dect (pattern_dect),
        .match_count  (match_count),
        .count_sat    (count_sat)
    );

    always #5 clk = ~clk;

    // Drive one cycle at the falling edge, sample the Mealy flag mid-cycle, return after the edge.
    task automatic send(input logic d, input logic v, output logic det);
        @(negedge clk);
        data_in = d;
        valid   = v;
        #1 det = pattern_dect;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic det;
        @(negedge clk);
        rst = 1'b1; valid = 1'b1; data_in = 1'b1;
        #1 det = pattern_dect;
        total++;
        if (det !== 1'b0) begin bad++; $display("FAIL reset_dect got=%b exp=0", det); end
        @(posedge clk);
        #1 rst = 1'b0; valid = 1'b0;
        total++;
        if (match_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", match_count); end
        total++;
        if (count_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", count_sat); end
        $display("test_reset: count=%0d sat=%b", match_count, count_sat);
    endtask

    task automatic test_overlap();
        logic [10:0] bits = 11'b10110110110;
        logic [10:0] exp  = 11'b00001001001;
        logic det;
        overlap_en = 1'b1;
        for (int i = 10; i >= 0; i--) begin
            send(bits[i], 1'b1, det);
            total++;
            if (det !== exp[i]) begin bad++; $display("FAIL overlap_bit%0d got=%b exp=%b", 11 - i, det, exp[i]); end
            $display("overlap bit%0d data=%b dect=%b", 11 - i, bits[i], det);
        end
        total++;
        if (match_count !== 2'd3) begin bad++; $display("FAIL overlap_count got=%0d exp=3", match_count); end
        total++;
        if (count_sat !== 1'b1) begin bad++; $display("FAIL overlap_sat got=%b exp=1", count_sat); end
    endtask

    task automatic test_non_overlap();
        logic [10:0] bits = 11'b10110110110;
        logic [10:0] exp  = 11'b00001000001;
        logic det;
        pulse_reset();
        overlap_en = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            send(bits[i], 1'b1, det);
            total++;
            if (det !== exp[i]) begin bad++; $display("FAIL nonovl_bit%0d got=%b exp=%b", 11 - i, det, exp[i]); end
            $display("nonovl bit%0d data=%b dect=%b", 11 - i, bits[i], det);
        end
        total++;
        if (match_count !== 2'd2) begin bad++; $display("FAIL nonovl_count got=%0d exp=2", match_count); end
        total++;
        if (count_sat !== 1'b0) begin bad++; $display("FAIL nonovl_sat got=%b exp=0", count_sat); end
        overlap_en = 1'b1;
    endtask

    task automatic test_gaps();
        logic [4:0] bits = 5'b10110;
        logic det;
        pulse_reset();
        for (int i = 4; i >= 0; i--) begin
            send(bits[i], 1'b1, det);
            total++;
            if (det !== (i == 0)) begin bad++; $display("FAIL gap_bit%0d got=%b exp=%b", 5 - i, det, (i == 0)); end
            $display("gaps bit%0d data=%b dect=%b", 5 - i, bits[i], det);
            if (i != 0) begin
                for (int g = 0; g < 2; g++) begin
                    send(1'b1, 1'b0, det);
                    total++;
                    if (det !== 1'b0) begin bad++; $display("FAIL gap_idle%0d got=%b exp=0", 5 - i, det); end
                end
            end
        end
        total++;
        if (match_count !== 2'd1) begin bad++; $display("FAIL gap_count got=%0d exp=1", match_count); end
    endtask

    task automatic test_pat_load();
        logic [4:0] bits = 5'b11100;
        logic det;
        pat_in   = 5'b11100;
        pat_load = 1'b1;
        send(1'b1, 1'b1, det);
        pat_load = 1'b0;
        total++;
        if (det !== 1'b0) begin bad++; $display("FAIL load_cycle got=%b exp=0", det); end
        for (int i = 4; i >= 0; i--) begin
            send(bits[i], 1'b1, det);
            total++;
            if (det !== (i == 0)) begin bad++; $display("FAIL load_bit%0d got=%b exp=%b", 5 - i, det, (i == 0)); end
            $display("pat_load bit%0d data=%b dect=%b", 5 - i, bits[i], det);
        end
        total++;
        if (match_count !== 2'd2) begin bad++; $display("FAIL load_count got=%0d exp=2", match_count); end
    endtask

    task automatic test_saturate();
        logic [13:0] bits = 14'b10110110110110;
        logic [2:0]  tail = 3'b110;
        logic det;
        pulse_reset();
        overlap_en = 1'b1;
        for (int i = 13; i >= 0; i--) begin
            send(bits[i], 1'b1, det);
        end
        total++;
        if (match_count !== 2'd3) begin bad++; $display("FAIL sat_count got=%0d exp=3", match_count); end
        total++;
        if (count_sat !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b exp=1", count_sat); end
        $display("saturate: count=%0d sat=%b", match_count, count_sat);
        for (int i = 2; i >= 0; i--) begin
            cnt_clr = (i == 0);
            send(tail[i], 1'b1, det);
            cnt_clr = 1'b0;
            total++;
            if (det !== (i == 0)) begin bad++; $display("FAIL clr_bit%0d got=%b exp=%b", 3 - i, det, (i == 0)); end
        end
        total++;
        if (match_count !== 2'd0) begin bad++; $display("FAIL clr_count got=%0d exp=0", match_count); end
        total++;
        if (count_sat !== 1'b0) begin bad++; $display("FAIL clr_sat got=%b exp=0", count_sat); end
        $display("cnt_clr with match: count=%0d sat=%b", match_count, count_sat);
    endtask

    task automatic test_reset_midstream();
        logic [2:0] head = 3'b101;
        logic [1:0] rest = 2'b10;
        logic det;
        for (int i = 2; i >= 0; i--) send(head[i], 1'b1, det);
        pulse_reset();
        for (int i = 1; i >= 0; i--) begin
            send(rest[i], 1'b1, det);
            total++;
            if (det !== 1'b0) begin bad++; $display("FAIL midrst_bit%0d got=%b exp=0", 2 - i, det); end
        end
        total++;
        if (match_count !== 2'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", match_count); end
        $display("reset midstream: count=%0d", match_count);
    endtask

`ifdef SEQ_DET_MASK_EN
    task automatic test_mask();
        logic [4:0] bits = 5'b10010;
        logic det;
        pulse_reset();
        pat_mask = 5'b11011;
        for (int i = 4; i >= 0; i--) begin
            send(bits[i], 1'b1, det);
            total++;
            if (det !== (i == 0)) begin bad++; $display("FAIL mask_bit%0d got=%b exp=%b", 5 - i, det, (i == 0)); end
        end
        pat_mask = '1;
        $display("mask: count=%0d", match_count);
    endtask
`endif

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gaps();
        test_pat_load();
        test_saturate();
        test_reset_midstream();
`ifdef SEQ_DET_MASK_EN
        test_mask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
